mult_arbiter: RTL and testbench
===============================

Name: mult_arbiter

Overview:
- Shares one combinational signed 32x32 Booth multiplier between NUM_REQ requesters.
- Each requester has a valid/ready request port. Grants are round-robin.
- Operands are registered at accept, then the block waits MUL_CYCLES clocks as a multicycle settle window. The 64-bit product is returned with the requester id on a single valid/ready response port.
- Sits between CPU/DSP clients and the multiplier datapath. Provides the sequencing that the bare multiplier lacks.

Parameters:
- NUM_REQ, 4, number of requesters; 2..8.
- MUL_CYCLES, 2, settle cycles allowed for the combinational multiplier; >=1. A value of 0 is an elaboration error.
- ID_W, $clog2(NUM_REQ), derived width of the requester id.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept; at most one bit set.
- req_a  in  NUM_REQ*32  multiplicands; slice i = bits [32*i+31:32*i].
- req_b  in  NUM_REQ*32  multipliers; same slicing as req_a.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_id  out  ID_W  index of the requester that owns the response.
- rsp_result  out  64  signed two's-complement product a*b.
- busy  out  1  high whenever state is not IDLE.
- op_count  out  32  number of completed response handshakes; wraps 0xFFFF_FFFF -> 0.

Behaviour:
- States:
  - IDLE: accepts one request.
  - CALC: operands held stable; down-counter runs.
  - RESP: result presented on the response port.
- Reset (rst=0, async): state=IDLE; all other outputs and registers clear.
  - rsp_valid=0, rsp_id=0, rsp_result=0, busy=0, op_count=0.
  - Round-robin pointer=0; operand registers=0; cycle counter=0.
  - req_ready=0 while rst is low.
  - Reset mid-CALC or mid-RESP abandons the operation; no response is issued.
- Arbitration in IDLE:
  - Scan req_valid starting at the pointer, wrapping modulo NUM_REQ. The first set bit g is granted.
  - req_ready[g]=1 combinationally, only in IDLE. All req_ready bits are 0 in CALC and RESP.
  - On accept (req_valid[g] & req_ready[g]): capture req_a/req_b slice g and id g. Pointer <= (g+1) mod NUM_REQ. Counter <= MUL_CYCLES-1. Go to CALC.
  - With no valid request: stay in IDLE; pointer unchanged.
- CALC:
  - Multiplier inputs are driven only from the operand registers.
  - When counter==0: register the multiplier output into rsp_result, set rsp_valid=1, go to RESP.
  - Otherwise decrement the counter.
- RESP:
  - rsp_valid, rsp_id and rsp_result stay stable until rsp_ready=1.
  - On the handshake: rsp_valid<=0, op_count<=op_count+1, go to IDLE.
  - A new request is not accepted in the handshake cycle.
- Latency and throughput:
  - Accept edge at cycle t gives rsp_valid high from cycle t+MUL_CYCLES onward, counted in register updates after the accept.
  - Back-to-back throughput is one product per MUL_CYCLES+2 cycles when rsp_ready is held high.
- Arithmetic:
  - Operands are signed 32-bit; the product is the full signed 64-bit result; no truncation.
  - The multiplier's done output is ignored; timing is governed only by MUL_CYCLES.
- Edge cases:
  - A requester that drops req_valid before being granted loses nothing; arbitration is re-evaluated each IDLE cycle.
  - Requests presented while busy are held off by req_ready=0.
  - rsp_ready high while rsp_valid is low has no effect.

Decomposition:
- Shared package mult_pkg holds:
  - typedef mult_state_e {IDLE, CALC, RESP};
  - constants OPND_W=32 and PROD_W=64;
  - function rr_pick(valid, ptr), returning a one-hot grant and its index.
- Sub-module: one instance of Multiplier_32bit, the existing combinational Booth multiplier, fed from the operand registers.
- Arbiter logic stays inline in mult_arbiter. No separate arbiter module.

Test Plan:
- Reset: rst low mid-CALC -> next cycle busy=0, rsp_valid=0, op_count=0, req_ready=0. After release, req0 is accepted first.
- Single op, MUL_CYCLES=2: req1 with a=7, b=6 at cycle t -> rsp_valid high 2 cycles after accept, rsp_id=1, rsp_result=42, busy high throughout.
- Signed: a=-3 (0xFFFF_FFFD), b=5 -> rsp_result=0xFFFF_FFFF_FFFF_FFF1. Then a=0x8000_0000, b=0x8000_0000 -> 0x4000_0000_0000_0000.
- Round-robin: all 4 requesters valid continuously -> grant order 0,1,2,3,0. op_count reaches 5. No grant while busy.
- Backpressure: rsp_ready held low 5 cycles in RESP -> rsp_valid, rsp_id and rsp_result stable. req_ready stays 0. op_count increments exactly once on release.
- Wrap: force op_count to 0xFFFF_FFFF, complete one op -> op_count=0.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared types, widths and the round-robin pick helper for the multiplier arbiter.
package mult_pkg;

    localparam int OPND_W    = 32;
    localparam int PROD_W    = 64;
    localparam int MAX_REQ   = 8;
    localparam int MAX_IDX_W = 3;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        RESP
    } mult_state_e;

    typedef struct packed {
        logic                 found;
        logic [MAX_REQ-1:0]   grant;
        logic [MAX_IDX_W-1:0] idx;
    } rr_pick_t;

    // Scan valid starting at ptr, wrapping modulo n; first set bit wins.
    function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0]   valid,
                                         input logic [MAX_IDX_W-1:0] ptr,
                                         input int unsigned          n);
        rr_pick_t             r;
        int unsigned          s;
        logic [MAX_IDX_W-1:0] j;
        r = '0;
        for (int unsigned k = 0; k < MAX_REQ; k++) begin
            s = (32'(ptr) + k) % n;
            j = s[MAX_IDX_W-1:0];
            if (!r.found && (k < n) && valid[j]) begin
                r.found    = 1'b1;
                r.idx      = j;
                r.grant[j] = 1'b1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/Multiplier_32bit.sv
// Combinational radix-2 Booth multiplier, signed 32x32 -> 64.
module Multiplier_32bit
    import mult_pkg::*;
(
    input  logic signed [OPND_W-1:0] a_i,
    input  logic signed [OPND_W-1:0] b_i,
    output logic signed [PROD_W-1:0] p_o,
    output logic                     done_o
);

    logic signed [PROD_W-1:0] a_ext;
    logic                     prev;

    assign a_ext  = {{(PROD_W-OPND_W){a_i[OPND_W-1]}}, a_i};
    assign done_o = 1'b1;

    // Each bit pair {b[i], b[i-1]} selects add, subtract or skip of a<<i.
    always_comb begin
        p_o  = '0;
        prev = 1'b0;
        for (int i = 0; i < OPND_W; i++) begin
            case ({b_i[i], prev})
                2'b01:   p_o = p_o + (a_ext <<< i);
                2'b10:   p_o = p_o - (a_ext <<< i);
                default: p_o = p_o;
            endcase
            prev = b_i[i];
        end
    end

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin arbiter sharing one combinational multiplier among NUM_REQ
// requesters, with a fixed multicycle settle window and a valid/ready response.
module mult_arbiter
    import mult_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int MUL_CYCLES = 2,
    parameter int ID_W       = $clog2(NUM_REQ)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [NUM_REQ*OPND_W-1:0]   req_a,
    input  logic [NUM_REQ*OPND_W-1:0]   req_b,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [ID_W-1:0]             rsp_id,
    output logic [PROD_W-1:0]           rsp_result,
    output logic                        busy,
    output logic [31:0]                 op_count
);

    localparam int CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

    generate
        if (MUL_CYCLES < 1 || NUM_REQ < 2 || NUM_REQ > MAX_REQ) begin : g_param_err
            $error("mult_arbiter: MUL_CYCLES must be >= 1 and NUM_REQ in 2..8");
        end
    endgenerate

    mult_state_e              state_q, state_d;
    logic [ID_W-1:0]          ptr_q, ptr_d;
    logic [ID_W-1:0]          id_q, id_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic signed [OPND_W-1:0] a_q, a_d;
    logic signed [OPND_W-1:0] b_q, b_d;
    logic [PROD_W-1:0]        result_q, result_d;
    logic                     rsp_valid_q, rsp_valid_d;
    logic [31:0]              op_count_q, op_count_d;

    logic [MAX_REQ-1:0]       valid_ext;
    logic [MAX_IDX_W-1:0]     ptr_ext;
    rr_pick_t                 pick;
    logic [ID_W-1:0]          gnt_id;
    logic                     pick_spare_unused;

    logic signed [PROD_W-1:0] mul_p;
    logic                     mul_done_unused;

    Multiplier_32bit u_mul (
        .a_i    (a_q),
        .b_i    (b_q),
        .p_o    (mul_p),
        .done_o (mul_done_unused)
    );

    always_comb begin
        valid_ext                = '0;
        valid_ext[NUM_REQ-1:0]   = req_valid;
        ptr_ext                  = '0;
        ptr_ext[ID_W-1:0]        = ptr_q;
        pick                     = rr_pick(valid_ext, ptr_ext, NUM_REQ);
        gnt_id                   = pick.idx[ID_W-1:0];
    end

    assign pick_spare_unused = |{pick.grant, pick.idx, pick.found};

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        id_d        = id_q;
        cnt_d       = cnt_q;
        a_d         = a_q;
        b_d         = b_q;
        result_d    = result_q;
        rsp_valid_d = rsp_valid_q;
        op_count_d  = op_count_q;
        req_ready   = '0;
        case (state_q)
            IDLE: begin
                // Gated by rst so no requester sees a grant while held in reset.
                if (rst && pick.found) begin
                    req_ready = pick.grant[NUM_REQ-1:0];
                    a_d       = req_a[OPND_W*gnt_id +: OPND_W];
                    b_d       = req_b[OPND_W*gnt_id +: OPND_W];
                    id_d      = gnt_id;
                    ptr_d     = (gnt_id == ID_W'(NUM_REQ-1)) ? '0 : gnt_id + ID_W'(1);
                    cnt_d     = CNT_W'(MUL_CYCLES-1);
                    state_d   = CALC;
                end
            end
            CALC: begin
                if (cnt_q == '0) begin
                    result_d    = mul_p;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    op_count_d  = op_count_q + 32'd1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            id_q        <= '0;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            result_q    <= '0;
            rsp_valid_q <= 1'b0;
            op_count_q  <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            id_q        <= id_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            result_q    <= result_d;
            rsp_valid_q <= rsp_valid_d;
            op_count_q  <= op_count_d;
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = id_q;
    assign rsp_result = result_q;
    assign busy       = (state_q != IDLE);
    assign op_count   = op_count_q;

endmodule

// File: tb/tb_mult_arbiter.sv
// Directed bench for mult_arbiter (NUM_REQ=4, MUL_CYCLES=2).
module tb_mult_arbiter;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*32-1:0] req_a, req_b;
    logic           rsp_valid, rsp_ready;
    logic [1:0]     rsp_id;
    logic [63:0]    rsp_result;
    logic           busy;
    logic [31:0]    op_count;

    int total = 0;
    int bad   = 0;

    mult_arbiter #(.NUM_REQ(N), .MUL_CYCLES(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .busy       (busy),
        .op_count   (op_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge with the DUT idle; completes one operation.
    task automatic run_op(input int id, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input string tag);
        req_valid          = 4'(1 << id);
        req_a[32*id +: 32] = a;
        req_b[32*id +: 32] = b;
        #1;
        chk({tag, " ready"}, 64'(req_ready), 64'(1 << id));
        @(negedge clk);
        req_valid = '0;
        #1;
        chk({tag, " busy"}, 64'(busy), 64'd1);
        chk({tag, " held off"}, 64'(req_ready), 64'd0);
        @(negedge clk);
        chk({tag, " early valid"}, 64'(rsp_valid), 64'd0);
        @(negedge clk);
        chk({tag, " valid"}, 64'(rsp_valid), 64'd1);
        chk({tag, " id"}, 64'(rsp_id), 64'(id));
        chk({tag, " result"}, rsp_result, exp);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        #1;
        chk({tag, " done"}, 64'(rsp_valid), 64'd0);
        chk({tag, " idle"}, 64'(busy), 64'd0);
    endtask

    initial begin
        rst       = 1'b0;
        req_valid = 4'hF;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst busy", 64'(busy), 64'd0);
        chk("rst rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst rsp_result", rsp_result, 64'd0);
        chk("rst op_count", 64'(op_count), 64'd0);
        chk("rst req_ready", 64'(req_ready), 64'd0);
        req_valid = '0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        run_op(1, 32'd7, 32'd6, 64'd42, "single");
        chk("single op_count", 64'(op_count), 64'd1);

        // Reset in the middle of CALC abandons the operation.
        req_valid = 4'b0100;
        req_a[64 +: 32] = 32'd3;
        req_b[64 +: 32] = 32'd3;
        @(negedge clk);
        chk("calc busy", 64'(busy), 64'd1);
        for (int i = 0; i < N; i++) begin
            req_a[32*i +: 32] = 32'(i + 1);
            req_b[32*i +: 32] = 32'd10;
        end
        req_valid = 4'hF;
        rst = 1'b0;
        #1;
        chk("midcalc busy", 64'(busy), 64'd0);
        chk("midcalc rsp_valid", 64'(rsp_valid), 64'd0);
        chk("midcalc op_count", 64'(op_count), 64'd0);
        chk("midcalc req_ready", 64'(req_ready), 64'd0);
        @(negedge clk);
        rst       = 1'b1;
        rsp_ready = 1'b1;

        for (int k = 0; k < 5; k++) begin
            #1;
            chk("rr grant", 64'(req_ready), 64'(1 << (k % N)));
            @(negedge clk);
            chk("rr busy hold", 64'(req_ready), 64'd0);
            @(negedge clk);
            @(negedge clk);
            chk("rr valid", 64'(rsp_valid), 64'd1);
            chk("rr id", 64'(rsp_id), 64'(k % N));
            chk("rr result", rsp_result, 64'((k % N + 1) * 10));
            @(negedge clk);
        end
        req_valid = '0;
        rsp_ready = 1'b0;
        #1;
        chk("rr op_count", 64'(op_count), 64'd5);

        run_op(1, 32'hFFFF_FFFD, 32'd5, 64'hFFFF_FFFF_FFFF_FFF1, "neg");
        run_op(2, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, "minmin");
        run_op(3, 32'h7FFF_FFFF, 32'h8000_0000, 64'hC000_0000_8000_0000, "maxmin");
        chk("signed op_count", 64'(op_count), 64'd8);

        // Backpressure with every requester still asking.
        req_valid = 4'hF;
        req_a[0 +: 32] = 32'hFFFF_FFFF;
        req_b[0 +: 32] = 32'hFFFF_FFFF;
        #1;
        chk("bp grant", 64'(req_ready), 64'd1);
        repeat (3) @(negedge clk);
        chk("bp valid", 64'(rsp_valid), 64'd1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("bp hold valid", 64'(rsp_valid), 64'd1);
            chk("bp hold id", 64'(rsp_id), 64'd0);
            chk("bp hold result", rsp_result, 64'd1);
            chk("bp hold ready", 64'(req_ready), 64'd0);
            chk("bp hold count", 64'(op_count), 64'd8);
        end
        rsp_ready = 1'b1;
        req_valid = '0;
        @(negedge clk);
        rsp_ready = 1'b0;
        #1;
        chk("bp release valid", 64'(rsp_valid), 64'd0);
        chk("bp release count", 64'(op_count), 64'd9);

        rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("idle rsp_ready count", 64'(op_count), 64'd9);
        chk("idle rsp_ready valid", 64'(rsp_valid), 64'd0);

        force dut.op_count_q = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.op_count_q;
        #1;
        chk("wrap pre", 64'(op_count), 64'hFFFF_FFFF);
        run_op(3, 32'd0, 32'd12345678, 64'd0, "wrap op");
        chk("wrap post", 64'(op_count), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
